fifo_stream_out: RTL and testbench

Read-side adapter that sits directly downstream of the dual-clock FIFO's read port, in the read clock domain. It drains the FIFO's show-ahead read interface (data valid whenever not empty, advanced by a pop strobe) into a registered valid/ready stream through a two-entry buffer. It also frames the stream into fixed-length packets and counts completed packets. All outputs to the downstream consumer are registered, and no combinational path runs from the consumer's ready signal back to the FIFO pop.

---
 rtl/fifo_stream_pkg.sv | 10 +
 rtl/stream_skid2.sv | 67 ++++++
 rtl/fifo_stream_out.sv | 70 +++++++
 tb/tb_fifo_stream_out.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_pkg.sv
// rtl/fifo_stream_pkg.sv - shared types for the FIFO read-side stream adapter
package fifo_stream_pkg;
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   localparam int CNT_W = 16;
endpackage

// File: rtl/stream_skid2.sv
// rtl/stream_skid2.sv - two-entry registered buffer between a fill port and a valid/ready stream
module stream_skid2
   import fifo_stream_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_space,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);
   state_t           state_q;
   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] tail_q;
   logic             valid_q;
   logic             take;

   assign take      = valid_q && out_ready;
   assign in_space  = (state_q != ST_TWO);
   assign out_data  = head_q;
   assign out_valid = valid_q;

   // Head always feeds the consumer; tail only ever catches the word popped during a stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_valid) begin
                  head_q  <= in_data;
                  valid_q <= 1'b1;
                  state_q <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_valid && take) begin
                  head_q <= in_data;
               end else if (in_valid) begin
                  tail_q  <= in_data;
                  state_q <= ST_TWO;
               end else if (take) begin
                  valid_q <= 1'b0;
                  state_q <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (take) begin
                  head_q  <= tail_q;
                  state_q <= ST_ONE;
               end
            end
            default: begin
               state_q <= ST_EMPTY;
               valid_q <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: rtl/fifo_stream_out.sv
// rtl/fifo_stream_out.sv - drains a show-ahead FIFO read port into a framed, registered stream
module fifo_stream_out
   import fifo_stream_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int PKT_LEN = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] fifo_data,
   input  logic             fifo_empty,
   output logic             fifo_pop,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_last,
   output logic [CNT_W-1:0] pkt_cnt
);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

   logic             in_space;
   logic             take;
   logic             valid_next;
   logic [CNT_W-1:0] beat_q;
   logic [CNT_W-1:0] beat_d;
   logic             last_q;
   logic [CNT_W-1:0] pkt_cnt_q;

   // Pop depends only on buffer occupancy, never on m_ready.
   assign fifo_pop = !rst && !fifo_empty && in_space;
   assign take     = m_valid && m_ready;

   stream_skid2 #(.WIDTH(WIDTH)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_data  (fifo_data),
      .in_valid (fifo_pop),
      .in_space (in_space),
      .out_data (m_data),
      .out_valid(m_valid),
      .out_ready(m_ready)
   );

   // Mirror of the buffer's next m_valid so m_last can be registered alongside it.
   assign valid_next = fifo_pop || (m_valid && (!take || !in_space));

   always_comb begin
      beat_d = beat_q;
      if (take) begin
         beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_q    <= '0;
         last_q    <= 1'b0;
         pkt_cnt_q <= '0;
      end else begin
         beat_q <= beat_d;
         last_q <= valid_next && (beat_d == LAST_BEAT);
         if (take && last_q) begin
            pkt_cnt_q <= pkt_cnt_q + 1'b1;
         end
      end
   end

   assign m_last  = last_q;
   assign pkt_cnt = pkt_cnt_q;
endmodule

// File: tb/tb_fifo_stream_out.sv
// tb/tb_fifo_stream_out.sv - scoreboard bench for fifo_stream_out
module tb_fifo_stream_out;
   import fifo_stream_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] fifo_data = '0;
   logic        fifo_empty = 1'b1;
   logic        fifo_pop;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic        m_last;
   logic [15:0] pkt_cnt;

   logic        rst1 = 1'b1;
   logic [31:0] fifo_data1 = 32'h0000_0001;
   logic        fifo_empty1 = 1'b0;
   logic        fifo_pop1;
   logic [31:0] m_data1;
   logic        m_valid1;
   logic        m_ready1 = 1'b1;
   logic        m_last1;
   logic [15:0] pkt_cnt1;

   int          chk = 0;
   int          err = 0;
   int          exp_idx = 0;
   logic [31:0] fifo_q[$];
   logic [32:0] exp_q[$];
   logic        pop_seen = 1'b0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = '0;

   fifo_stream_out #(.WIDTH(32), .PKT_LEN(4)) dut (
      .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
      .fifo_pop(fifo_pop), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_last(m_last), .pkt_cnt(pkt_cnt)
   );

   fifo_stream_out #(.WIDTH(32), .PKT_LEN(1)) dut1 (
      .clk(clk), .rst(rst1), .fifo_data(fifo_data1), .fifo_empty(fifo_empty1),
      .fifo_pop(fifo_pop1), .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1),
      .m_last(m_last1), .pkt_cnt(pkt_cnt1)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      chk++;
      if (act !== expv) begin
         err++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic push_word(input logic [31:0] w);
      fifo_q.push_back(w);
      exp_q.push_back({(exp_idx % 4 == 3), w});
      exp_idx++;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      m_ready = 1'b0;
      fifo_q.delete();
      exp_q.delete();
      exp_idx = 0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Show-ahead FIFO model: head and empty flag change only at the clock edge.
   always @(posedge clk) begin
      if (pop_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
      fifo_empty <= (fifo_q.size() == 0);
      fifo_data  <= (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
   end

   // Monitor: compares every presented word against the scoreboard head.
   always begin
      @(negedge clk);
      #4;
      pop_seen = fifo_pop;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 64'(m_valid), 64'd1);
            check("stall_data", 64'(m_data), 64'(prev_data));
         end
         if (m_valid) begin
            if (exp_q.size() == 0) begin
               chk++;
               err++;
               $display("FAIL spurious_word: got %0h expected none", m_data);
            end else begin
               check("sb_data", 64'(m_data), 64'(exp_q[0][31:0]));
               check("sb_last", 64'(m_last), 64'(exp_q[0][32]));
               if (m_ready) void'(exp_q.pop_front());
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
      end
   end

   initial begin
      int pops, pop_i, val_i, cnt, first_i, last_i, sent, guard, takes1;
      logic [31:0] vdata;
      logic        vlast, done;

      // Reset state
      step();
      step();
      check("rst_valid", 64'(m_valid), 64'd0);
      check("rst_last", 64'(m_last), 64'd0);
      check("rst_data", 64'(m_data), 64'd0);
      check("rst_pkt", 64'(pkt_cnt), 64'd0);
      check("rst_pop", 64'(fifo_pop), 64'd0);
      rst = 1'b0;
      step();

      // Single word
      m_ready = 1'b0;
      push_word(32'hA5A5_0001);
      pops = 0; pop_i = -1; val_i = -1; vdata = '0; vlast = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step();
         if (fifo_pop) begin pops++; pop_i = i; end
         if (m_valid && val_i < 0) begin val_i = i; vdata = m_data; vlast = m_last; end
      end
      check("single_pops", 64'(pops), 64'd1);
      check("single_latency", 64'(val_i), 64'(pop_i + 1));
      check("single_data", 64'(vdata), 64'hA5A5_0001);
      check("single_last", 64'(vlast), 64'd0);
      m_ready = 1'b1;
      repeat (3) step();

      // Streaming 1..8, PKT_LEN=4
      reset_dut();
      m_ready = 1'b1;
      for (int w = 1; w <= 8; w++) push_word(32'(w));
      cnt = 0; first_i = -1; last_i = -1;
      for (int i = 0; i < 16; i++) begin
         step();
         if (m_valid) begin
            cnt++;
            if (first_i < 0) first_i = i;
            last_i = i;
         end
      end
      check("stream_count", 64'(cnt), 64'd8);
      check("stream_span", 64'(last_i - first_i), 64'd7);
      check("stream_pkts", 64'(pkt_cnt), 64'd2);

      // Stall with 5 words
      reset_dut();
      m_ready = 1'b0;
      for (int w = 1; w <= 5; w++) push_word(32'h50 + 32'(w));
      pops = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (fifo_pop) pops++;
      end
      check("stall_pops", 64'(pops), 64'd2);
      check("stall_state", 64'(dut.u_skid.state_q), 64'(ST_TWO));
      check("stall_pop_low", 64'(fifo_pop), 64'd0);
      check("stall_head", 64'(m_data), 64'h51);
      m_ready = 1'b1;
      cnt = 0; last_i = -1;
      for (int i = 0; i < 12; i++) begin
         if (i == 0) check("restart_pop0", 64'(fifo_pop), 64'd0);
         if (i == 1) check("restart_pop1", 64'(fifo_pop), 64'd1);
         if (m_valid) begin cnt++; last_i = i; end
         step();
      end
      check("restart_count", 64'(cnt), 64'd5);
      check("restart_span", 64'(last_i), 64'd4);

      // Random backpressure and fill
      reset_dut();
      sent = 0; guard = 0;
      while ((sent < 1000 || exp_q.size() != 0) && guard < 20000) begin
         m_ready = 1'($urandom_range(1, 0));
         if (sent < 1000 && $urandom_range(1, 0) == 1) begin
            for (int k = 0; k < int'($urandom_range(3, 1)) && sent < 1000; k++) begin
               push_word($urandom);
               sent++;
            end
         end
         step();
         guard++;
      end
      m_ready = 1'b1;
      step();
      check("rand_drain", 64'(exp_q.size()), 64'd0);
      check("rand_pkts", 64'(pkt_cnt), 64'd250);

      // Reset mid-packet while in ST_TWO
      reset_dut();
      m_ready = 1'b0;
      for (int w = 1; w <= 6; w++) push_word(32'h100 + 32'(w));
      repeat (4) step();
      m_ready = 1'b1;
      step();
      step();
      m_ready = 1'b0;
      step();
      check("mid_state", 64'(dut.u_skid.state_q), 64'(ST_TWO));
      check("mid_taken", 64'(exp_q.size()), 64'd4);
      rst = 1'b1;
      fifo_q.delete();
      exp_q.delete();
      exp_idx = 0;
      #1;
      check("mid_rst_valid", 64'(m_valid), 64'd0);
      check("mid_rst_last", 64'(m_last), 64'd0);
      check("mid_rst_data", 64'(m_data), 64'd0);
      check("mid_rst_pkt", 64'(pkt_cnt), 64'd0);
      check("mid_rst_pop", 64'(fifo_pop), 64'd0);
      step();
      step();
      rst = 1'b0;
      m_ready = 1'b1;
      for (int w = 1; w <= 4; w++) push_word(32'h200 + 32'(w));
      repeat (10) step();
      check("mid_new_pkts", 64'(pkt_cnt), 64'd1);
      check("mid_new_drain", 64'(exp_q.size()), 64'd0);

      // PKT_LEN=1: pkt_cnt wrap after 65536 packets
      rst1 = 1'b0;
      takes1 = 0; done = 1'b0;
      for (int i = 0; i < 66000 && !done; i++) begin
         step();
         check("len1_last", 64'(m_last1), 64'(m_valid1));
         if (takes1 == 65535) check("wrap_full", 64'(pkt_cnt1), 64'hFFFF);
         if (takes1 == 65536) begin
            check("wrap_zero", 64'(pkt_cnt1), 64'd0);
            done = 1'b1;
         end
         if (m_valid1 && m_ready1) takes1++;
      end
      if (!done) begin
         chk++;
         err++;
         $display("FAIL wrap_timeout: got %0d takes expected 65536", takes1);
      end

      $display("Result: errors=%0d of %0d checks", err, chk);
      $finish;
   end
endmodule
